// File: rtl/pe_fi_pkg.sv
// Shared types and the fault-injection function for the runtime-configurable
// faulty output-stationary PE.
//  fi_target_e    : which value a fault lands on (weight, input, psum, none)
//  fi_mode_e      : how the mask is applied (flip, stuck-at-0, stuck-at-1, none)
//  fi_win_state_e : activation window FSM states
//  fi_apply()     : applies mask to a value according to the mode
package pe_fi_pkg;

  // Widest value fi_apply handles; callers cast in and out explicitly.
  localparam int unsigned FI_MAX_W = 64;

  typedef enum logic [1:0] {
    FI_T_WEIGHT = 2'd0,
    FI_T_INPUT  = 2'd1,
    FI_T_PSUM   = 2'd2,
    FI_T_NONE   = 2'd3
  } fi_target_e;

  typedef enum logic [1:0] {
    FI_M_FLIP = 2'd0,
    FI_M_SA0  = 2'd1,
    FI_M_SA1  = 2'd2,
    FI_M_NONE = 2'd3
  } fi_mode_e;

  typedef enum logic [1:0] {
    FI_IDLE   = 2'd0,
    FI_WAIT   = 2'd1,
    FI_ACTIVE = 2'd2,
    FI_DONE   = 2'd3
  } fi_win_state_e;

  function automatic logic [FI_MAX_W-1:0] fi_apply(input logic [FI_MAX_W-1:0] value,
                                                   input logic [FI_MAX_W-1:0] mask,
                                                   input fi_mode_e            mode);
    case (mode)
      FI_M_FLIP: fi_apply = value ^ mask;
      FI_M_SA0:  fi_apply = value & ~mask;
      FI_M_SA1:  fi_apply = value | mask;
      default:   fi_apply = value;
    endcase
  endfunction

endpackage

// File: rtl/pe_fi_window.sv
// Fault configuration latch and activation window.
//  clk, rst          : clock, synchronous active-high reset
//  i_arm             : latch config, restart the cycle counter
//  i_target/i_mode   : fault target and mode, sampled only with i_arm
//  i_mask            : fault mask, sampled only with i_arm
//  i_start, i_len    : first active cycle after arm, active length (0 = permanent)
//  o_active          : registered window-active flag
//  o_target/o_mode/o_mask : latched configuration
module pe_fi_window
  import pe_fi_pkg::*;
#(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_arm,
  input  logic [1:0]       i_target,
  input  logic [1:0]       i_mode,
  input  logic [ACC_W-1:0] i_mask,
  input  logic [CNT_W-1:0] i_start,
  input  logic [CNT_W-1:0] i_len,
  output logic             o_active,
  output fi_target_e       o_target,
  output fi_mode_e         o_mode,
  output logic [ACC_W-1:0] o_mask
);

  fi_win_state_e    r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_start;
  logic [CNT_W-1:0] r_len;
  logic             r_active;

  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_end;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Window end saturates so an overflowing start+len stays active until cnt saturates.
  assign w_sum     = {1'b0, r_start} + {1'b0, r_len};
  assign w_end     = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
  assign w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

  // The cycle right after arm has cnt=0; the window covers cnt in [start, start+len).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= FI_IDLE;
      r_cnt    <= '0;
      r_start  <= '0;
      r_len    <= '0;
      r_active <= 1'b0;
      o_target <= FI_T_NONE;
      o_mode   <= FI_M_NONE;
      o_mask   <= '0;
    end else if (i_arm) begin
      o_target <= fi_target_e'(i_target);
      o_mode   <= fi_mode_e'(i_mode);
      o_mask   <= i_mask;
      r_start  <= i_start;
      r_len    <= i_len;
      r_cnt    <= '0;
      if (i_start == '0) begin
        r_state  <= FI_ACTIVE;
        r_active <= 1'b1;
      end else begin
        r_state  <= FI_WAIT;
        r_active <= 1'b0;
      end
    end else begin
      case (r_state)
        FI_WAIT: begin
          r_cnt <= w_cnt_nxt;
          if (w_cnt_nxt == r_start) begin
            r_state  <= FI_ACTIVE;
            r_active <= 1'b1;
          end
        end
        FI_ACTIVE: begin
          r_cnt <= w_cnt_nxt;
          if ((r_len != '0) && (w_cnt_nxt == w_end)) begin
            r_state  <= FI_DONE;
            r_active <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_active = r_active;

endmodule

// File: rtl/pe_os_fi_gen.sv
// Output-stationary systolic PE with runtime-configurable fault injection.
// Optional build macro PE_FI_STATS_EN enables the fault_hits counter.
//  clk, rst              : clock, synchronous active-high reset
//  init                  : first operand pair of a new tile; finished tile moves to the drain
//  in_a / out_a          : activation in from the left, post-fault activation out to the right
//  in_b / out_b          : weight in from above, post-fault weight out downwards
//  in_data/in_valid      : drain chain input from the upstream PE
//  out_data/out_valid    : drain chain output
//  fault_arm             : latch fault config, restart window
//  fault_target/mode/mask/start/len : fault configuration
//  fault_active          : window active
//  drain_ovf             : sticky, drain data was lost
//  fault_hits            : cycles where injection changed a value (0 without PE_FI_STATS_EN)
module pe_os_fi_gen
  import pe_fi_pkg::*;
#(
  parameter int unsigned D_W   = 8,
  parameter int unsigned ACC_W = 2 * D_W,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned ROW   = 0,
  parameter int unsigned COL   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic [D_W-1:0]   in_a,
  input  logic [D_W-1:0]   in_b,
  output logic [D_W-1:0]   out_a,
  output logic [D_W-1:0]   out_b,
  input  logic [ACC_W-1:0] in_data,
  input  logic             in_valid,
  output logic [ACC_W-1:0] out_data,
  output logic             out_valid,
  input  logic             fault_arm,
  input  logic [1:0]       fault_target,
  input  logic [1:0]       fault_mode,
  input  logic [ACC_W-1:0] fault_mask,
  input  logic [CNT_W-1:0] fault_start,
  input  logic [CNT_W-1:0] fault_len,
  output logic             fault_active,
  output logic             drain_ovf,
  output logic [CNT_W-1:0] fault_hits
);

  // Reject parameter sets the datapath or trace tags cannot represent.
  if (ACC_W < 2 * D_W || ACC_W > FI_MAX_W || ROW > 32'hFFFF || COL > 32'hFFFF) begin : g_bad_params
    $error("pe_os_fi_gen: unsupported parameter set");
  end

  fi_target_e       w_cfg_target;
  fi_mode_e         w_cfg_mode;
  logic [ACC_W-1:0] w_cfg_mask;

  pe_fi_window #(
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) u_window (
    .clk      (clk),
    .rst      (rst),
    .i_arm    (fault_arm),
    .i_target (fault_target),
    .i_mode   (fault_mode),
    .i_mask   (fault_mask),
    .i_start  (fault_start),
    .i_len    (fault_len),
    .o_active (fault_active),
    .o_target (w_cfg_target),
    .o_mode   (w_cfg_mode),
    .o_mask   (w_cfg_mask)
  );

  logic [D_W-1:0]   r_a;
  logic [D_W-1:0]   r_b;
  logic             r_init;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_rsrv;
  logic             r_rsrv_v;
  logic [ACC_W-1:0] r_hold;
  logic             r_hold_v;
  logic [ACC_W-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_ovf;

  logic             w_inj_a;
  logic             w_inj_b;
  logic             w_inj_p;
  logic [D_W-1:0]   w_a_eff;
  logic [D_W-1:0]   w_b_eff;
  logic [ACC_W-1:0] w_acc_eff;
  logic [ACC_W-1:0] w_prod;

  // Faults act on the stored operand/psum registers, so they also propagate to neighbours.
  assign w_inj_a   = fault_active && (w_cfg_target == FI_T_INPUT);
  assign w_inj_b   = fault_active && (w_cfg_target == FI_T_WEIGHT);
  assign w_inj_p   = fault_active && (w_cfg_target == FI_T_PSUM);
  assign w_a_eff   = w_inj_a ? D_W'(fi_apply(FI_MAX_W'(r_a), FI_MAX_W'(w_cfg_mask), w_cfg_mode)) : r_a;
  assign w_b_eff   = w_inj_b ? D_W'(fi_apply(FI_MAX_W'(r_b), FI_MAX_W'(w_cfg_mask), w_cfg_mode)) : r_b;
  assign w_acc_eff = w_inj_p ? ACC_W'(fi_apply(FI_MAX_W'(r_acc), FI_MAX_W'(w_cfg_mask), w_cfg_mode)) : r_acc;
  assign w_prod    = ACC_W'(w_a_eff) * ACC_W'(w_b_eff);

  // Operand stage, MAC and drain chain (own result > held > upstream).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_init      <= 1'b0;
      r_acc       <= '0;
      r_rsrv      <= '0;
      r_rsrv_v    <= 1'b0;
      r_hold      <= '0;
      r_hold_v    <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_a    <= in_a;
      r_b    <= in_b;
      r_init <= init;
      r_acc  <= (r_init ? '0 : w_acc_eff) + w_prod;

      r_out_valid <= 1'b0;
      if (r_rsrv_v) begin
        r_out_data  <= r_rsrv;
        r_out_valid <= 1'b1;
        r_rsrv_v    <= 1'b0;
        if (in_valid) begin
          if (!r_hold_v) begin
            r_hold   <= in_data;
            r_hold_v <= 1'b1;
          end else begin
            r_ovf <= 1'b1;
          end
        end
      end else if (r_hold_v) begin
        r_out_data  <= r_hold;
        r_out_valid <= 1'b1;
        if (in_valid) r_hold <= in_data;
        else          r_hold_v <= 1'b0;
      end else if (in_valid) begin
        r_out_data  <= in_data;
        r_out_valid <= 1'b1;
      end

      // Placed after the drain so a new tile result wins over the clear above.
      if (r_init) begin
        r_rsrv   <= w_acc_eff;
        r_rsrv_v <= 1'b1;
        if (r_rsrv_v) r_ovf <= 1'b1;
      end
    end
  end

  assign out_a     = w_a_eff;
  assign out_b     = w_b_eff;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign drain_ovf = r_ovf;

`ifdef PE_FI_STATS_EN
  logic [CNT_W-1:0] r_hits;
  logic             w_hit;

  assign w_hit = (w_inj_a && (w_a_eff != r_a)) ||
                 (w_inj_b && (w_b_eff != r_b)) ||
                 (w_inj_p && (w_acc_eff != r_acc));

  // Saturating count of cycles where an injection altered a value.
  always_ff @(posedge clk) begin
    if (rst || fault_arm) r_hits <= '0;
    else if (w_hit && !(&r_hits)) r_hits <= r_hits + CNT_W'(1);
  end

  assign fault_hits = r_hits;
`else
  assign fault_hits = '0;
`endif

endmodule

// File: tb/tb_pe_os_fi_gen.sv
// Directed bench for pe_os_fi_gen (D_W=8, ACC_W=16, CNT_W=16).
module tb_pe_os_fi_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        init;
  logic [7:0]  in_a, in_b, out_a, out_b;
  logic [15:0] in_data, out_data;
  logic        in_valid, out_valid;
  logic        fault_arm;
  logic [1:0]  fault_target, fault_mode;
  logic [15:0] fault_mask, fault_start, fault_len;
  logic        fault_active, drain_ovf;
  logic [15:0] fault_hits;

  int n_vec = 0;
  int n_err = 0;

`ifdef PE_FI_STATS_EN
  localparam logic [31:0] HITS_MID = 32'd1;
  localparam logic [31:0] HITS_END = 32'd2;
`else
  localparam logic [31:0] HITS_MID = 32'd0;
  localparam logic [31:0] HITS_END = 32'd0;
`endif

  always #5 clk = ~clk;

  pe_os_fi_gen #(
    .D_W   (8),
    .ACC_W (16),
    .CNT_W (16),
    .ROW   (0),
    .COL   (0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .init         (init),
    .in_a         (in_a),
    .in_b         (in_b),
    .out_a        (out_a),
    .out_b        (out_b),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .fault_arm    (fault_arm),
    .fault_target (fault_target),
    .fault_mode   (fault_mode),
    .fault_mask   (fault_mask),
    .fault_start  (fault_start),
    .fault_len    (fault_len),
    .fault_active (fault_active),
    .drain_ovf    (drain_ovf),
    .fault_hits   (fault_hits)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic i, input logic [7:0] a, input logic [7:0] b);
    init = i;
    in_a = a;
    in_b = b;
    tick();
  endtask

  task automatic arm(input logic [1:0] tgt, input logic [1:0] mode, input logic [15:0] mask,
                     input logic [15:0] start, input logic [15:0] len);
    fault_arm    = 1'b1;
    fault_target = tgt;
    fault_mode   = mode;
    fault_mask   = mask;
    fault_start  = start;
    fault_len    = len;
  endtask

  task automatic disarm();
    fault_arm    = 1'b0;
    fault_target = 2'd2;
    fault_mode   = 2'd2;
    fault_mask   = 16'hFFFF;
    fault_start  = 16'd7;
    fault_len    = 16'd3;
  endtask

  initial begin
    rst = 1'b1; init = 1'b0; in_a = '0; in_b = '0; in_data = '0; in_valid = 1'b0;
    fault_arm = 1'b0; fault_target = 2'd3; fault_mode = 2'd3;
    fault_mask = '0; fault_start = '0; fault_len = '0;
    tick(); tick();
    chk("rst_out_a",   32'(out_a), 32'd0);
    chk("rst_out_b",   32'(out_b), 32'd0);
    chk("rst_valid",   32'(out_valid), 32'd0);
    chk("rst_data",    32'(out_data), 32'd0);
    chk("rst_active",  32'(fault_active), 32'd0);
    chk("rst_ovf",     32'(drain_ovf), 32'd0);
    chk("rst_hits",    32'(fault_hits), 32'd0);
    rst = 1'b0;

    // Fault-free tile: 4 x (3*4) = 48
    op(1, 3, 4);
    chk("t1_out_a", 32'(out_a), 32'd3);
    op(0, 3, 4); op(0, 3, 4); op(0, 3, 4);
    op(1, 0, 0); op(0, 0, 0);
    chk("t1_pre_valid", 32'(out_valid), 32'd0);
    op(0, 0, 0);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data",  32'(out_data), 32'd48);
    op(0, 0, 0);
    chk("t1_post_valid", 32'(out_valid), 32'd0);

    // Weight flip bit 0, permanent from arm: b 4 -> 5, 4 x (3*5) = 60
    arm(2'd0, 2'd0, 16'h0001, 16'd0, 16'd0);
    op(0, 0, 0);
    disarm();
    chk("t2_active", 32'(fault_active), 32'd1);
    chk("t2_out_b_zero", 32'(out_b), 32'd1);
    op(1, 3, 4);
    chk("t2_out_b0", 32'(out_b), 32'd5);
    op(0, 3, 4);
    chk("t2_out_b1", 32'(out_b), 32'd5);
    op(0, 3, 4);
    chk("t2_out_b2", 32'(out_b), 32'd5);
    op(0, 3, 4);
    chk("t2_out_b3", 32'(out_b), 32'd5);
    op(1, 0, 0); op(0, 0, 0); op(0, 0, 0);
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_data",  32'(out_data), 32'd60);

    // Psum SA1 bit 15, start=2 len=1: one-cycle window, 4 + 0x8000
    arm(2'd2, 2'd2, 16'h8000, 16'd2, 16'd1);
    op(1, 1, 1);
    disarm();
    chk("t3_act_c0", 32'(fault_active), 32'd0);
    op(0, 1, 1);
    chk("t3_act_c1", 32'(fault_active), 32'd0);
    op(0, 1, 1);
    chk("t3_act_c2", 32'(fault_active), 32'd1);
    op(0, 1, 1);
    chk("t3_act_c3", 32'(fault_active), 32'd0);
    op(1, 0, 0);
    chk("t3_act_c4", 32'(fault_active), 32'd0);
    op(0, 0, 0); op(0, 0, 0);
    chk("t3_valid", 32'(out_valid), 32'd1);
    chk("t3_data",  32'(out_data), 32'h8004);

    // Drain collisions: own 12, then held upstream words, then a lost word
    op(1, 2, 3); op(0, 2, 3); op(1, 0, 0); op(0, 0, 0);
    in_valid = 1'b1; in_data = 16'hAAAA;
    op(0, 0, 0);
    chk("t4_own_valid", 32'(out_valid), 32'd1);
    chk("t4_own_data",  32'(out_data), 32'd12);
    in_data = 16'hBBBB;
    op(1, 0, 0);
    chk("t4_hold_a", 32'(out_data), 32'hAAAA);
    in_data = 16'hCCCC;
    op(0, 0, 0);
    chk("t4_hold_b", 32'(out_data), 32'hBBBB);
    chk("t4_ovf_clear", 32'(drain_ovf), 32'd0);
    in_data = 16'hDDDD;
    op(0, 0, 0);
    chk("t4_own2_data", 32'(out_data), 32'd0);
    chk("t4_ovf_set", 32'(drain_ovf), 32'd1);
    in_valid = 1'b0;
    op(0, 0, 0);
    chk("t4_hold_c", 32'(out_data), 32'hCCCC);
    op(0, 0, 0);
    chk("t4_idle_valid", 32'(out_valid), 32'd0);
    chk("t4_ovf_sticky", 32'(drain_ovf), 32'd1);

    // Reset mid-drain, then a fresh tile 5*6 = 30
    arm(2'd3, 2'd3, 16'h0000, 16'd0, 16'd0);
    in_valid = 1'b1; in_data = 16'h1234;
    op(0, 0, 0);
    disarm();
    chk("t5_fwd_data", 32'(out_data), 32'h1234);
    chk("t5_active", 32'(fault_active), 32'd1);
    rst = 1'b1;
    op(0, 0, 0);
    chk("t5_rst_valid",  32'(out_valid), 32'd0);
    chk("t5_rst_active", 32'(fault_active), 32'd0);
    chk("t5_rst_ovf",    32'(drain_ovf), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    op(1, 5, 6); op(0, 0, 0); op(1, 0, 0);
    chk("t5_first_valid", 32'(out_valid), 32'd1);
    chk("t5_first_data",  32'(out_data), 32'd0);
    op(0, 0, 0); op(0, 0, 0);
    chk("t5_valid", 32'(out_valid), 32'd1);
    chk("t5_data",  32'(out_data), 32'd30);
    chk("t5_ovf",   32'(drain_ovf), 32'd0);

    // Input SA0 mask 0xFF: only the two a=5 cycles change a value
    arm(2'd1, 2'd1, 16'h00FF, 16'd0, 16'd0);
    op(0, 0, 0);
    disarm();
    chk("t6_active", 32'(fault_active), 32'd1);
    op(0, 0, 0); op(0, 0, 0); op(0, 0, 0);
    chk("t6_hits_zero", 32'(fault_hits), 32'd0);
    op(0, 5, 0);
    chk("t6_out_a_forced", 32'(out_a), 32'd0);
    op(0, 5, 0);
    chk("t6_hits_mid", 32'(fault_hits), HITS_MID);
    op(0, 0, 0); op(0, 0, 0);
    chk("t6_hits_end", 32'(fault_hits), HITS_END);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
